// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full flag, level and sticky overflow for an async FIFO.
// Optional almost-full output is compiled in with `define WPTR_ALMOST_FULL_EN.
module wptr_full_ctrl #(
    parameter int ASIZE     = 4,
    parameter int AF_THRESH = 14
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic             wovf_clr,
    input  logic [ASIZE:0]   s_rptr,
    output logic             wen,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic [ASIZE:0]   wlevel,
    output logic             wovf
`ifdef WPTR_ALMOST_FULL_EN
    ,
    output logic             walmost_full
`endif
);

    logic [ASIZE:0] wbin_q, wbin_d;
    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] wlevel_q, wlevel_d;
    logic [ASIZE:0] rbin;
    logic           wfull_q, wfull_d;
    logic           wovf_q, wovf_d;

    assign wen   = winc & ~wfull_q;
    assign waddr = wbin_q[ASIZE-1:0];
    assign wptr  = wptr_q;
    assign wfull = wfull_q;
    assign wlevel = wlevel_q;
    assign wovf  = wovf_q;

    always_comb begin
        rbin = '0;
        rbin[ASIZE] = s_rptr[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ s_rptr[i];
        end
    end

    always_comb begin
        wbin_d   = wbin_q + {{ASIZE{1'b0}}, wen};
        wptr_d   = wbin_d ^ (wbin_d >> 1);
        // Full when the write Gray pointer is one lap ahead of the read pointer.
        wfull_d  = (wptr_d == {~s_rptr[ASIZE:ASIZE-1], s_rptr[ASIZE-2:0]});
        wlevel_d = wbin_d - rbin;
        // Set has priority over clear.
        wovf_d   = (winc & wfull_q) | (wovf_q & ~wovf_clr);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
        end
    end

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [ASIZE:0] AF_T = (ASIZE+1)'(AF_THRESH);
    logic walmost_full_q, walmost_full_d;

    assign walmost_full_d = (wlevel_d >= AF_T);
    assign walmost_full   = walmost_full_q;

    always_ff @(posedge wclk) begin
        if (wrst) walmost_full_q <= 1'b0;
        else      walmost_full_q <= walmost_full_d;
    end
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl (ASIZE=4): driver queues expectations,
// monitor checks wen mid-cycle and registered outputs just after each edge.
module tb_wptr_full_ctrl;

    typedef struct packed {
        logic       chk_wen;
        logic       wen;
        logic [4:0] bin;
        logic       full;
        logic [4:0] lvl;
        logic       ovf;
        logic       af;
    } exp_t;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b0;
    logic       wovf_clr = 1'b0;
    logic [4:0] s_rptr = '0;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic [4:0] wlevel;
    logic       wovf;
`ifdef WPTR_ALMOST_FULL_EN
    logic       walmost_full;
`endif

    exp_t q[$];
    int nvec = 0;
    int nerr = 0;
    int pushed = 0;
    int checked = 0;

    always #5 wclk = ~wclk;

    wptr_full_ctrl #(.ASIZE(4), .AF_THRESH(14)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wovf_clr(wovf_clr),
        .s_rptr(s_rptr), .wen(wen), .waddr(waddr), .wptr(wptr),
        .wfull(wfull), .wlevel(wlevel), .wovf(wovf)
`ifdef WPTR_ALMOST_FULL_EN
        , .walmost_full(walmost_full)
`endif
    );

    function automatic logic [4:0] g(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s vec%0d: got %b expected %b", nm, checked, act, req);
        end
    endtask

    // Monitor: wen checked mid-cycle, registers checked right after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.chk_wen) chk("wen", {4'b0, wen}, {4'b0, e.wen});
                @(posedge wclk);
                #1;
                chk("wptr", wptr, g(int'(e.bin)));
                chk("waddr", {1'b0, waddr}, {1'b0, e.bin[3:0]});
                chk("wfull", {4'b0, wfull}, {4'b0, e.full});
                chk("wlevel", wlevel, e.lvl);
                chk("wovf", {4'b0, wovf}, {4'b0, e.ovf});
`ifdef WPTR_ALMOST_FULL_EN
                chk("walmost_full", {4'b0, walmost_full}, {4'b0, e.af});
`endif
                checked++;
            end
        end
    end

    task automatic vec(input logic rst, input logic inc, input logic clr, input logic [4:0] sr,
                       input logic cw, input logic w, input int bin, input logic full,
                       input int lvl, input logic ovf, input logic af);
        exp_t e;
        @(posedge wclk);
        #2;
        wrst = rst; winc = inc; wovf_clr = clr; s_rptr = sr;
        e.chk_wen = cw; e.wen = w; e.bin = bin[4:0]; e.full = full;
        e.lvl = lvl[4:0]; e.ovf = ovf; e.af = af;
        q.push_back(e);
        pushed++;
    endtask

    initial begin
        int to;
        // Reset
        vec(1, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        // Fill to full with s_rptr=0
        for (int i = 0; i < 16; i++)
            vec(0, 1, 0, 5'd0, 1, 1, i + 1, (i == 15), i + 1, 0, (i + 1 >= 14));
        // Overflow, clear, then set+clear together
        vec(0, 1, 0, 5'd0, 1, 0, 16, 1, 16, 1, 1);
        vec(0, 0, 1, 5'd0, 1, 0, 16, 1, 16, 0, 1);
        vec(0, 1, 1, 5'd0, 1, 0, 16, 1, 16, 1, 1);
        // Drain visible: read pointer advances to 4
        vec(0, 0, 0, 5'b00110, 1, 0, 16, 0, 12, 1, 0);
        vec(0, 1, 0, 5'b00110, 1, 1, 17, 0, 13, 1, 0);
        vec(0, 0, 1, 5'b00110, 1, 0, 17, 0, 13, 0, 0);
        // Wrap with reader trailing by 2
        for (int w = 18; w <= 33; w++)
            vec(0, 1, 0, g((w - 2) % 32), 1, 1, w % 32, 0, 2, 0, 0);
        // Walk to wbin=9 with reader at 1
        for (int w = 2; w <= 9; w++)
            vec(0, 1, 0, 5'b00001, 1, 1, w, 0, w - 1, 0, 0);
        // Reader at 25 makes wbin=9 full; overflow; then reset with winc high
        vec(0, 0, 0, g(25), 1, 0, 9, 1, 16, 0, 1);
        vec(0, 1, 0, g(25), 1, 0, 9, 1, 16, 1, 1);
        vec(1, 1, 0, g(25), 0, 0, 0, 0, 0, 0, 0);
        vec(0, 0, 0, 5'd0, 1, 0, 0, 0, 0, 0, 0);
        // Almost-full rise at 14 and fall when reader moves to 1
        for (int i = 0; i < 14; i++)
            vec(0, 1, 0, 5'd0, 1, 1, i + 1, 0, i + 1, 0, (i + 1 >= 14));
        vec(0, 0, 0, 5'b00001, 1, 0, 14, 0, 13, 0, 0);
        vec(0, 0, 0, 5'b00001, 1, 0, 14, 0, 13, 0, 0);

        to = 0;
        while (checked < pushed && to < 1000) begin
            @(posedge wclk);
            to++;
        end
        #3;
        if (checked < pushed) begin
            nvec++;
            nerr++;
            $display("FAIL timeout: checked %0d of %0d", checked, pushed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-side pointer and full-flag controller for the UART TX/RX asynchronous FIFO, in the write clock domain. Consumes the Gray read pointer after write-domain synchronization (s_rptr). Produces the binary write address for the FIFO RAM, the Gray write pointer sent to the read domain, and the registered full, level and sticky overflow status.

Parameters:
ASIZE, 4, address width; FIFO depth = 2**ASIZE; legal range ASIZE >= 2
AF_THRESH, 14, almost-full threshold in words; used only when the optional feature is compiled in; legal range 1..2**ASIZE

Ports:
wclk  input  1  write-domain clock; all state updates on rising edge
wrst  input  1  synchronous, active-high reset
winc  input  1  write request from the producer
wovf_clr  input  1  clears the sticky overflow flag
s_rptr  input  ASIZE+1  Gray read pointer, already synchronized into wclk by a 2-flop stage; no further synchronization in this block
wen  output  1  RAM write strobe; combinational, = winc & ~wfull
waddr  output  ASIZE  RAM write address; = wbin[ASIZE-1:0]
wptr  output  ASIZE+1  registered Gray write pointer, sent to the read domain
wfull  output  1  registered full flag
wlevel  output  ASIZE+1  registered write-side occupancy estimate, 0..2**ASIZE
wovf  output  1  sticky overflow flag
walmost_full  output  1  registered flag; present only with WPTR_ALMOST_FULL_EN

Behaviour:
- Reset: when wrst=1 at a wclk edge, next state is wbin=0, wptr=0, wfull=0, wlevel=0, wovf=0, walmost_full=0. winc and wovf_clr are ignored during reset. Reset mid-operation discards the pointer immediately. The read domain must be reset in the same system reset event; that is a system-level rule.
- Internal state: binary pointer wbin[ASIZE:0] plus registered wptr. wptr always equals gray(wbin) after any edge.
- Next-state pointers: wbin_next = wbin + (winc & ~wfull), modulo 2**(ASIZE+1). wgray_next = wbin_next ^ (wbin_next >> 1).
- Full detection: wfull <= (wgray_next == {~s_rptr[ASIZE:ASIZE-1], s_rptr[ASIZE-2:0]}). wfull asserts on the same edge that wptr reaches the full position. There is zero-cycle lag for self-induced full.
- Full deassertion: wfull deasserts on the first edge after a changed s_rptr is presented. This is pessimistic by the synchronizer latency, which is by design.
- Level: rbin = gray2bin(s_rptr) via an XOR prefix chain. wlevel <= (wbin_next - rbin) mod 2**(ASIZE+1). The value never exceeds 2**ASIZE under legal operation.
- Overflow: a write attempt while full (winc=1 while wfull=1) sets wovf on the next edge. The pointer, wptr and RAM are untouched (wen=0).
- Overflow clear: wovf_clr=1 clears wovf. If a set and a clear occur in the same cycle, set wins.
- Wrap-around: wbin wraps 2**(ASIZE+1)-1 -> 0. The Gray MSB toggle at wrap must not produce a false full.
- Simultaneous winc and a moving s_rptr in the same cycle: the write is accepted if the registered wfull=0. The full and level computations use the current s_rptr.
- No state machine beyond the pointer, flag and level registers. Latency from winc to wptr update is 1 cycle.

Optional Feature:
WPTR_ALMOST_FULL_EN
- Defined: walmost_full port exists; walmost_full <= (wbin_next - rbin) >= AF_THRESH; reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Fill to full (ASIZE=4, s_rptr=0): after reset, apply 16 consecutive winc. After the 16th edge: wptr=5'b11000, wfull=1, wlevel=16, waddr=0. wen was high for all 16 cycles.
2. Overflow and clear: a 17th winc while full gives wen=0 and wptr held at 11000, with wovf=1 on the next edge. Then wovf_clr=1 gives wovf=0. Then winc and wovf_clr together in the same cycle while full gives wovf=1 (set wins).
3. Drain visible: from full, drive s_rptr=5'b00110 (binary 4). On the next edge wfull=0 and wlevel=12, and the next winc is accepted.
4. Wrap: keep s_rptr trailing wbin by 2 while writing through wbin 31->0. wptr steps 10000 -> 00000, wfull stays 0 throughout, and wlevel stays 2.
5. Reset mid-operation: at wbin=9 with wovf=1, assert wrst for 1 cycle while winc=1. The next edge gives wptr=0, wfull=0, wlevel=0 and wovf=0, and no write is performed.
6. With WPTR_ALMOST_FULL_EN (AF_THRESH=14, s_rptr=0): walmost_full is 0 while wlevel<=13 and rises with the edge where wlevel becomes 14. It falls when s_rptr is advanced to gray(1)=00001 with wlevel at 14.
